// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            en,
  output logic [CNTW-1:0] cnt
);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  // Advance on an enabled event unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (en && inc && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/halt sequencing for the five-stage core
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNTW      = 16,
  parameter int DRAIN_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      idrs,
  input  logic [4:0]      idrt,
  input  logic            idusers,
  input  logic            iduserst,
  input  logic            idfin,
  input  logic            exmemrd,
  input  logic [4:0]      exrt,
  input  logic            membrtaken,
  input  logic            wbfin,
  output logic            pcwrite,
  output logic            ifidwrite,
  output logic            ifidflush,
  output logic            idexflush,
  output logic            exmemflush,
  output logic            halted,
  output logic            halterr,
  output logic [CNTW-1:0] stallcnt,
  output logic [CNTW-1:0] flushcnt
);

  localparam int DCW = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_MAX - 1);

  state_e         state_q, state_d;
  logic [DCW-1:0] draincnt_q, draincnt_d;
  logic           halterr_q, halterr_d;
  logic           loaduse;
  logic           stall_inc, flush_inc, cnt_en;

  // A load in EX whose destination a reading ID instruction needs; $0 never hazards.
  assign loaduse = exmemrd && (exrt != REG_ZERO) &&
                   ((idusers && (exrt == idrs)) || (iduserst && (exrt == idrt)));

  // Priority: HALT, then taken branch, then fin/drain, then load-use.
  always_comb begin
    state_d    = state_q;
    draincnt_d = draincnt_q;
    halterr_d  = halterr_q;
    pcwrite    = 1'b1;
    ifidwrite  = 1'b1;
    ifidflush  = 1'b0;
    idexflush  = 1'b0;
    exmemflush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state_q)
      RUN: begin
        if (membrtaken) begin
          ifidflush  = 1'b1;
          idexflush  = 1'b1;
          exmemflush = 1'b1;
          flush_inc  = 1'b1;
        end else if (idfin) begin
          // fin moves on into EX; nothing younger is allowed behind it.
          pcwrite    = 1'b0;
          ifidflush  = 1'b1;
          state_d    = DRAIN;
          draincnt_d = '0;
        end else if (loaduse) begin
          pcwrite   = 1'b0;
          ifidwrite = 1'b0;
          idexflush = 1'b1;
          stall_inc = 1'b1;
        end
      end
      DRAIN: begin
        pcwrite    = 1'b0;
        ifidflush  = 1'b1;
        draincnt_d = draincnt_q + DCW'(1);
        if (membrtaken) begin
          // An older taken branch squashes fin; resume at the branch target.
          pcwrite    = 1'b1;
          idexflush  = 1'b1;
          exmemflush = 1'b1;
          flush_inc  = 1'b1;
          state_d    = RUN;
        end else if (wbfin) begin
          state_d = HALT;
        end else if (draincnt_q == DRAIN_LAST) begin
          halterr_d = 1'b1;
          state_d   = HALT;
        end
      end
      HALT: begin
        pcwrite    = 1'b0;
        ifidwrite  = 1'b0;
        ifidflush  = 1'b1;
        idexflush  = 1'b1;
        exmemflush = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, drain timer and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      draincnt_q <= '0;
      halterr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      draincnt_q <= draincnt_d;
      halterr_q  <= halterr_d;
    end
  end

  assign halted  = (state_q == HALT);
  assign halterr = halterr_q;
  assign cnt_en  = (state_q != HALT);

  sat_counter #(.CNTW(CNTW)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .en  (cnt_en),
    .cnt (stallcnt)
  );

  sat_counter #(.CNTW(CNTW)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .en  (cnt_en),
    .cnt (flushcnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int CNTW = 4;
  localparam int DRAIN_MAX = 8;

  // {pcwrite, ifidwrite, ifidflush, idexflush, exmemflush, halted, halterr}
  localparam logic [6:0] C_RUN  = 7'b1100000;
  localparam logic [6:0] C_STL  = 7'b0001000;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_FIN  = 7'b0110000;
  localparam logic [6:0] C_HLT  = 7'b0011110;
  localparam logic [6:0] C_HERR = 7'b0011111;

  typedef struct {
    string           tag;
    logic [6:0]      ctrl;
    logic [CNTW-1:0] stall;
    logic [CNTW-1:0] flush;
  } exp_t;

  logic clk, rst;
  logic [4:0] idrs, idrt, exrt;
  logic idusers, iduserst, idfin, exmemrd, membrtaken, wbfin;
  logic pcwrite, ifidwrite, ifidflush, idexflush, exmemflush, halted, halterr;
  logic [CNTW-1:0] stallcnt, flushcnt;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  logic [CNTW-1:0] exp_stall, exp_flush;

  pipe_hazard_ctrl #(.CNTW(CNTW), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .idrs       (idrs),
    .idrt       (idrt),
    .idusers    (idusers),
    .iduserst   (iduserst),
    .idfin      (idfin),
    .exmemrd    (exmemrd),
    .exrt       (exrt),
    .membrtaken (membrtaken),
    .wbfin      (wbfin),
    .pcwrite    (pcwrite),
    .ifidwrite  (ifidwrite),
    .ifidflush  (ifidflush),
    .idexflush  (idexflush),
    .exmemflush (exmemflush),
    .halted     (halted),
    .halterr    (halterr),
    .stallcnt   (stallcnt),
    .flushcnt   (flushcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    idrs = 5'd0; idrt = 5'd0; exrt = 5'd0;
    idusers = 1'b0; iduserst = 1'b0; idfin = 1'b0;
    exmemrd = 1'b0; membrtaken = 1'b0; wbfin = 1'b0;
  endtask

  task automatic set_loaduse_rs(input logic [4:0] r);
    exmemrd = 1'b1; exrt = r; idrs = r; idusers = 1'b1;
  endtask

  task automatic bump_stall();
    if (exp_stall != {CNTW{1'b1}}) exp_stall = exp_stall + 1'b1;
  endtask

  task automatic bump_flush();
    if (exp_flush != {CNTW{1'b1}}) exp_flush = exp_flush + 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  // Push the expectation for this cycle, compare mid-cycle, then step past the edge.
  task automatic step(input string tag, input logic [6:0] ctrl_exp);
    exp_t e;
    logic [6:0] obs;
    sb_q.push_back('{tag, ctrl_exp, exp_stall, exp_flush});
    @(negedge clk);
    e = sb_q.pop_front();
    obs = {pcwrite, ifidwrite, ifidflush, idexflush, exmemflush, halted, halterr};
    checks++;
    assert (obs === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.ctrl);
    end
    checks++;
    assert (stallcnt === e.stall) else begin
      errors++;
      $error("FAIL %s stallcnt observed=%0d expected=%0d", e.tag, stallcnt, e.stall);
    end
    checks++;
    assert (flushcnt === e.flush) else begin
      errors++;
      $error("FAIL %s flushcnt observed=%0d expected=%0d", e.tag, flushcnt, e.flush);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    exp_stall = '0;
    exp_flush = '0;
    do_reset();
    step("reset", C_RUN);

    // Load-use on Rs: one bubble, then the load has moved on.
    set_loaduse_rs(5'd5);
    step("lu_rs", C_STL); bump_stall();
    clear_inputs();
    step("lu_after", C_RUN);
    // Load-use on Rt only.
    exmemrd = 1'b1; exrt = 5'd7; idrt = 5'd7; iduserst = 1'b1; idrs = 5'd7;
    step("lu_rt", C_STL); bump_stall();
    clear_inputs();
    // $0 destination never stalls.
    exmemrd = 1'b1; exrt = 5'd0; idrs = 5'd0; idusers = 1'b1;
    step("lu_zero", C_RUN);
    // Matching register but not read.
    exmemrd = 1'b1; exrt = 5'd5; idrs = 5'd5; idusers = 1'b0;
    step("lu_unused", C_RUN);
    // Matching register but EX is not a load.
    exmemrd = 1'b0; idusers = 1'b1;
    step("lu_noload", C_RUN);
    clear_inputs();

    // Taken branch overrides a simultaneous load-use.
    set_loaduse_rs(5'd9); membrtaken = 1'b1;
    step("br_lu", C_BR); bump_flush();
    clear_inputs();
    step("br_after", C_RUN);

    // Nominal fin drain and halt.
    idfin = 1'b1;
    step("fin_id", C_FIN);
    idfin = 1'b0;
    step("fin_d1", C_FIN);
    step("fin_d2", C_FIN);
    wbfin = 1'b1;
    step("fin_d3_wb", C_FIN);
    wbfin = 1'b0;
    step("halt", C_HLT);
    set_loaduse_rs(5'd3); membrtaken = 1'b1; idfin = 1'b1;
    step("halt_frozen", C_HLT);
    clear_inputs();
    step("halt_sticky", C_HLT);

    // Squashed fin.
    do_reset();
    step("rst_after_halt", C_RUN);
    idfin = 1'b1;
    step("sq_fin_id", C_FIN);
    idfin = 1'b0;
    step("sq_d1", C_FIN);
    membrtaken = 1'b1;
    step("sq_d2_br", C_BR); bump_flush();
    membrtaken = 1'b0;
    step("sq_run", C_RUN);

    // Drain timeout; load-use during drain is ignored.
    idfin = 1'b1;
    step("to_fin_id", C_FIN);
    idfin = 1'b0;
    set_loaduse_rs(5'd4);
    for (int i = 0; i < DRAIN_MAX; i++) step($sformatf("to_d%0d", i), C_FIN);
    clear_inputs();
    step("to_halterr", C_HERR);

    // Counter saturation.
    do_reset();
    step("rst_after_to", C_RUN);
    set_loaduse_rs(5'd6);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_%0d", i), C_STL);
      bump_stall();
    end
    clear_inputs();
    step("sat_hold", C_RUN);

    // Reset mid-drain wins over wbfin on the same edge.
    membrtaken = 1'b1;
    step("pre_drain_br", C_BR); bump_flush();
    membrtaken = 1'b0;
    idfin = 1'b1;
    step("md_fin_id", C_FIN);
    idfin = 1'b0;
    step("md_d1", C_FIN);
    wbfin = 1'b1;
    do_reset();
    wbfin = 1'b0;
    step("md_rst", C_RUN);
    step("md_rst_run", C_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage semiMIPS core. Each cycle it decides whether the PC and IF/ID register advance, stall or flush, and drives the synchronous `flush` inputs of ID/EX and EX/MEM. It sequences program termination: it drains the pipeline behind a `fin` instruction and parks the core in a sticky halt. Saturating performance counters record stall and flush events.

## Interface
Parameters:
- `CNTW`, 16: width of the performance counters.
- `DRAIN_MAX`, 8: drain-timeout cycle limit, ≥4.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `idrs`, `idrt`  in  5 each  Rs and Rt fields of the instruction in ID (IF/ID outputs).
- `idusers`, `iduserst`  in  1 each  the ID instruction reads Rs / Rt.
- `idfin`  in  1  the ID instruction is `fin`.
- `exmemrd`  in  1  ID/EX `memrdout`: EX holds a load.
- `exrt`  in  5  ID/EX `rtout`: destination of the load in EX.
- `membrtaken`  in  1  branch/jump in MEM resolved taken (qualified `bb*`/`jump` outputs).
- `wbfin`  in  1  `finout` of MEM/WB: `fin` has reached WB.
- `pcwrite`  out  1  PC update enable.
- `ifidwrite`  out  1  IF/ID load enable.
- `ifidflush`, `idexflush`, `exmemflush`  out  1 each  synchronous flush requests to the pipeline registers.
- `halted`  out  1  core halted (sticky).
- `halterr`  out  1  drain timeout occurred (sticky).
- `stallcnt`, `flushcnt`  out  CNTW each  saturating event counters.

## Operation
- FSM states: RUN, DRAIN, HALT. Reset state is RUN.
- `loaduse` = `exmemrd` & (`exrt`≠0) & ((`idusers` & `exrt`==`idrs`) | (`iduserst` & `exrt`==`idrt`)).
- Outputs are combinational from the state and the current inputs, with this priority: HALT > `membrtaken` > DRAIN/`idfin` > `loaduse`.
- RUN:
  - When `membrtaken` is set: `ifidflush`, `idexflush` and `exmemflush` are 1, `pcwrite`=`ifidwrite`=1, `flushcnt`+1, and `loaduse`/`idfin` are ignored. The state stays RUN.
  - Otherwise, when `idfin` is set: `pcwrite`=0 and `ifidflush`=1. The `fin` instruction advances into EX. The state goes to DRAIN and `draincnt` is set to 0.
  - Otherwise, when `loaduse` is set: `pcwrite`=`ifidwrite`=0, `idexflush`=1, `stallcnt`+1.
  - Otherwise all enables are 1 and all flushes are 0.
- DRAIN:
  - `pcwrite`=0, `ifidflush`=1, `draincnt`+1 each cycle.
  - When `membrtaken` is set, an older branch squashes `fin`: all three flushes are 1, `pcwrite`=1, `flushcnt`+1, and the state goes to RUN.
  - Otherwise, when `wbfin` is set, the state goes to HALT.
  - Otherwise, when `draincnt`==DRAIN_MAX-1, `halterr` is set and the state goes to HALT.
- HALT: `pcwrite`=`ifidwrite`=0, `ifidflush`=`idexflush`=`exmemflush`=1, `halted`=1. The state is left only by `rst`.
- Counters saturate at 2^CNTW-1 and do not wrap. They do not count in HALT.

## Timing
- Reset: after the first `clk` edge with `rst`=1, the state is RUN, `halted`=`halterr`=0, counters=0 and `draincnt`=0. Combinational outputs then show the RUN defaults: `pcwrite`=`ifidwrite`=1 and all flushes 0, subject to the inputs in that cycle.
- `rst` asserted in any state, including mid-DRAIN, wins over every other event on that edge.
- Load-use costs exactly one bubble. `loaduse` is deasserted in the next cycle because the load has moved to MEM.
- Branch penalty is 3 slots, all flushed in the same cycle `membrtaken` is high.
- Nominal `fin` drain: `wbfin` arrives 3 cycles after the DRAIN entry edge, so `halted` rises 4 cycles after `idfin` was sampled.
- `membrtaken` and `wbfin` in the same DRAIN cycle: `membrtaken` wins (go to RUN). This combination is unreachable in legal code but is defined anyway.

## Structure
- Package `pipe_pkg` holds the state enum `{RUN, DRAIN, HALT}` and the constant `REG_ZERO` = 5'd0.
- Sub-module `sat_counter` (parameter CNTW; ports `clk`, `rst`, `inc`, `en`, `cnt`) is instantiated twice.
- The FSM, `draincnt` and the hazard compare live in the top module.

## Test plan
- **Load-use:** load `lw $5` in EX (`exmemrd`=1, `exrt`=5); ID reads `idrs`=5 with `idusers`=1. Required: for exactly 1 cycle, `pcwrite`=0, `ifidwrite`=0, `idexflush`=1, and `stallcnt` goes 0→1. With `exrt`=0 instead, no stall.
- **Branch taken:** `membrtaken`=1 together with `loaduse`=1. Required: the three flushes are 1, `pcwrite`=1, `stallcnt` is unchanged, and `flushcnt` increments by 1.
- **Normal halt:** `idfin`=1 for 1 cycle, then `wbfin`=1 three cycles later. Required: `pcwrite`=0 from the `idfin` cycle onward, `halted`=1 on the 4th edge, `halterr`=0, and outputs frozen until `rst`.
- **Squashed fin:** enter DRAIN, then `membrtaken`=1 on the 2nd DRAIN cycle. Required: return to RUN, `pcwrite`=1, `halted` stays 0.
- **Timeout:** enter DRAIN and never assert `wbfin`, with DRAIN_MAX=8. Required: `halted`=`halterr`=1 after 8 DRAIN cycles.
- **Saturation/reset:** with CNTW=4, hold `loaduse` for 20 cycles. Required: `stallcnt` holds at 15. Assert `rst` mid-DRAIN. Required: state RUN, all counters 0.
